// File: rtl/mem_arb.sv
// mem_arb: two-master arbiter for the single-port data RAM.
// M0 (pipeline EX/MEM data port) has fixed priority over M1 (loader/debug),
// except while M1 holds a bus lock. Grants and the RAM drive are combinational;
// read data is steered back to the master that issued the read one cycle earlier.
// Optional feature: define MEM_ARB_STARVE_GUARD_EN to bound how long a locked
// M1 burst may hold off a waiting M0 (MAX_LOCK cycles).
module mem_arb #(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_LOCK = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [DW/8-1:0]   m0_wem_i,
  input  logic [AW-1:0]     m0_addr_i,
  input  logic [DW-1:0]     m0_data_i,
  output logic [DW-1:0]     m0_data_o,
  output logic              m0_hold_o,
  input  logic              m1_req_i,
  input  logic              m1_lock_i,
  input  logic              m1_we_i,
  input  logic [DW/8-1:0]   m1_wem_i,
  input  logic [AW-1:0]     m1_addr_i,
  input  logic [DW-1:0]     m1_data_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [DW-1:0]     m1_data_o,
  output logic              ram_cs_o,
  output logic              ram_we_o,
  output logic [DW/8-1:0]   ram_wem_o,
  output logic [AW-1:0]     ram_addr_o,
  output logic [DW-1:0]     ram_wdata_o,
  input  logic [DW-1:0]     ram_rdata_i
);

  typedef enum logic {IDLE, LOCK1} state_t;
  typedef enum logic [1:0] {RD_NONE, RD_M0, RD_M1} rd_sel_t;

  // A lock that can never be held is a configuration error.
  if (MAX_LOCK < 1) begin : g_max_lock_chk
    $error("mem_arb: MAX_LOCK must be at least 1");
  end

  state_t  state_q, state_d;
  rd_sel_t rd_sel_q, rd_sel_d;
  logic    gnt0, gnt1;
  logic    starve;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int unsigned CW = $clog2(MAX_LOCK + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  // Lock has held off a requesting M0 for MAX_LOCK cycles: this cycle goes to M0.
  assign starve = (state_q == LOCK1) && (cnt_q == CW'(MAX_LOCK));

  // Count consecutive locked cycles in which M0 is waiting.
  always_comb begin
    cnt_d = '0;
    if ((state_q == LOCK1) && (state_d == LOCK1) && m0_req_i && !starve)
      cnt_d = cnt_q + CW'(1);
  end

  // Starvation counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  assign starve = 1'b0;
`endif

  // Next-state, grant and read-tracking decode; everything gated off during reset.
  always_comb begin
    state_d  = state_q;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    rd_sel_d = RD_NONE;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          gnt0 = m0_req_i;
          gnt1 = m1_req_i & ~m0_req_i;
          if (gnt1 && m1_lock_i) state_d = LOCK1;
        end
        LOCK1: begin
          if (starve) begin
            gnt0    = m0_req_i;
            gnt1    = m1_req_i & ~m0_req_i;
            state_d = IDLE;
          end else begin
            gnt1 = m1_req_i;
            if (!m1_lock_i) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
      if (gnt0 && !m0_we_i)      rd_sel_d = RD_M0;
      else if (gnt1 && !m1_we_i) rd_sel_d = RD_M1;
    end
  end

  // State and read-owner registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rd_sel_q <= RD_NONE;
    end else begin
      state_q  <= state_d;
      rd_sel_q <= rd_sel_d;
    end
  end

  // RAM port mux: the winning master's fields, all zero when nobody is granted.
  always_comb begin
    ram_cs_o    = gnt0 | gnt1;
    ram_we_o    = 1'b0;
    ram_wem_o   = '0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (gnt0) begin
      ram_we_o    = m0_we_i;
      ram_wem_o   = m0_wem_i;
      ram_addr_o  = m0_addr_i;
      ram_wdata_o = m0_data_i;
    end else if (gnt1) begin
      ram_we_o    = m1_we_i;
      ram_wem_o   = m1_wem_i;
      ram_addr_o  = m1_addr_i;
      ram_wdata_o = m1_data_i;
    end
  end

  assign m0_hold_o   = m0_req_i & ~gnt0 & ~rst;
  assign m1_gnt_o    = gnt1;
  assign m1_rvalid_o = (rd_sel_q == RD_M1);
  assign m0_data_o   = (rd_sel_q == RD_M0) ? ram_rdata_i : '0;
  assign m1_data_o   = (rd_sel_q == RD_M1) ? ram_rdata_i : '0;

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed scoreboard bench for mem_arb with a behavioural RAM.
// Each stimulus cycle pushes its hand-computed expected outputs; a negedge
// monitor pops one record per cycle and compares. Build with or without
// MEM_ARB_STARVE_GUARD_EN; the starvation scenario expects the matching outcome.
module tb_mem_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req, m0_we, m1_req, m1_lock, m1_we;
  logic [3:0]  m0_wem, m1_wem, ram_wem;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [31:0] m0_rdata, m1_rdata, ram_addr, ram_wdata, ram_rdata;
  logic        m0_hold, m1_gnt, m1_rvalid, ram_cs, ram_we;

  typedef struct {
    string       tag;
    bit          hold, gnt1, cs, rv;
    logic [31:0] d0, d1, addr;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [31:0] mem [int unsigned];

  always #5 clk = ~clk;

  mem_arb #(.AW(32), .DW(32), .MAX_LOCK(16)) dut (
    .clk(clk), .rst(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_wem_i(m0_wem), .m0_addr_i(m0_addr),
    .m0_data_i(m0_wdata), .m0_data_o(m0_rdata), .m0_hold_o(m0_hold),
    .m1_req_i(m1_req), .m1_lock_i(m1_lock), .m1_we_i(m1_we), .m1_wem_i(m1_wem),
    .m1_addr_i(m1_addr), .m1_data_i(m1_wdata), .m1_gnt_o(m1_gnt),
    .m1_rvalid_o(m1_rvalid), .m1_data_o(m1_rdata),
    .ram_cs_o(ram_cs), .ram_we_o(ram_we), .ram_wem_o(ram_wem),
    .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
  );

  // Synchronous single-port RAM model with byte mask.
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) begin
        logic [31:0] w;
        w = mem.exists(ram_addr) ? mem[ram_addr] : 32'h0;
        for (int b = 0; b < 4; b++)
          if (ram_wem[b]) w[8*b +: 8] = ram_wdata[8*b +: 8];
        mem[ram_addr] = w;
      end else begin
        ram_rdata <= mem.exists(ram_addr) ? mem[ram_addr] : 32'h0;
      end
    end
  end

  task automatic chk(input string tag, input string fld, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s.%s: got %h, expected %h", tag, fld, act, req);
    end
  endtask

  // Monitor: one expected record per stimulus cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.tag, "m0_hold", 32'(m0_hold), 32'(e.hold));
      chk(e.tag, "m1_gnt", 32'(m1_gnt), 32'(e.gnt1));
      chk(e.tag, "ram_cs", 32'(ram_cs), 32'(e.cs));
      chk(e.tag, "m1_rvalid", 32'(m1_rvalid), 32'(e.rv));
      chk(e.tag, "m0_data", m0_rdata, e.d0);
      chk(e.tag, "m1_data", m1_rdata, e.d1);
      chk(e.tag, "ram_addr", ram_addr, e.addr);
    end
  end

  // Drive one cycle of inputs just after the clock edge and queue its expectation.
  task automatic cyc(input bit r,
                     input bit q0, input bit w0, input logic [31:0] a0, input logic [31:0] dd0,
                     input bit q1, input bit l1, input bit w1, input logic [31:0] a1, input logic [31:0] dd1,
                     input bit eh, input bit eg, input bit ecs, input bit erv,
                     input logic [31:0] ed0, input logic [31:0] ed1, input logic [31:0] ea,
                     input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    m0_req = q0; m0_we = w0; m0_wem = w0 ? 4'hF : 4'h0; m0_addr = a0; m0_wdata = dd0;
    m1_req = q1; m1_lock = l1; m1_we = w1; m1_wem = w1 ? 4'hF : 4'h0; m1_addr = a1; m1_wdata = dd1;
    e.tag = tag; e.hold = eh; e.gnt1 = eg; e.cs = ecs; e.rv = erv;
    e.d0 = ed0; e.d1 = ed1; e.addr = ea;
    exp_q.push_back(e);
  endtask

  task automatic idle(input bit erv, input logic [31:0] ed0, input logic [31:0] ed1, input string tag);
    cyc(0, 0,0,0,0, 0,0,0,0,0, 0,0,0,erv, ed0, ed1, 32'h0, tag);
  endtask

  initial begin
    m0_req = 0; m0_we = 0; m0_wem = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_lock = 0; m1_we = 0; m1_wem = 0; m1_addr = 0; m1_wdata = 0;
    ram_rdata = 0;
    mem[32'h100] = 32'hDEADBEEF;
    mem[32'h104] = 32'h11111111;
    mem[32'h108] = 32'h22222222;
    mem[32'h400] = 32'h44444444;

    // Reset with both masters requesting: every output must be zero.
    cyc(1, 1,0,32'h100,0, 1,1,0,32'h108,0, 0,0,0,0, 0,0,0, "rst_a");
    cyc(1, 1,0,32'h100,0, 1,1,0,32'h108,0, 0,0,0,0, 0,0,0, "rst_b");
    idle(0, 0, 0, "post_rst");

    // M0 read alone.
    cyc(0, 1,0,32'h100,0, 0,0,0,0,0, 0,0,1,0, 0,0,32'h100, "m0_rd");
    idle(0, 32'hDEADBEEF, 0, "m0_rd_data");

    // Simultaneous request: M0 wins, M1 served once M0 drops.
    cyc(0, 1,0,32'h104,0, 1,0,0,32'h108,0, 0,0,1,0, 0,0,32'h104, "prio_m0");
    cyc(0, 0,0,0,0, 1,0,0,32'h108,0, 0,1,1,0, 32'h11111111,0,32'h108, "prio_m1");
    idle(1, 0, 32'h22222222, "prio_m1_data");

    // Locked 4-beat write burst; M0 waits from beat 2 until after the lock drops.
    cyc(0, 0,0,0,0, 1,1,1,32'h200,32'hA0A0A0A0, 0,1,1,0, 0,0,32'h200, "burst0");
    cyc(0, 1,0,32'h104,0, 1,1,1,32'h204,32'hA1A1A1A1, 1,1,1,0, 0,0,32'h204, "burst1");
    cyc(0, 1,0,32'h104,0, 1,1,1,32'h208,32'hA2A2A2A2, 1,1,1,0, 0,0,32'h208, "burst2");
    cyc(0, 1,0,32'h104,0, 1,0,1,32'h20C,32'hA3A3A3A3, 1,1,1,0, 0,0,32'h20C, "burst3");
    cyc(0, 1,0,32'h104,0, 0,0,0,0,0, 0,0,1,0, 0,0,32'h104, "burst_m0");
    idle(0, 32'h11111111, 0, "burst_m0_data");

    // Back-to-back M1 readback of the burst.
    cyc(0, 0,0,0,0, 1,0,0,32'h200,0, 0,1,1,0, 0,0,32'h200, "rb0");
    cyc(0, 0,0,0,0, 1,0,0,32'h204,0, 0,1,1,1, 0,32'hA0A0A0A0,32'h204, "rb1");
    cyc(0, 0,0,0,0, 1,0,0,32'h208,0, 0,1,1,1, 0,32'hA1A1A1A1,32'h208, "rb2");
    cyc(0, 0,0,0,0, 1,0,0,32'h20C,0, 0,1,1,1, 0,32'hA2A2A2A2,32'h20C, "rb3");
    idle(1, 0, 32'hA3A3A3A3, "rb_last");

    // Starvation: M1 holds a read lock, M0 requests continuously.
    cyc(0, 0,0,0,0, 1,1,0,32'h400,0, 0,1,1,0, 0,0,32'h400, "lock_start");
    for (int k = 0; k < 16; k++)
      cyc(0, 1,0,32'h104,0, 1,1,0,32'h400,0, 1,1,1,1, 0,32'h44444444,32'h400, "starve_wait");
`ifdef MEM_ARB_STARVE_GUARD_EN
    cyc(0, 1,0,32'h104,0, 1,1,0,32'h400,0, 0,0,1,1, 0,32'h44444444,32'h104, "guard_m0");
    cyc(0, 1,0,32'h104,0, 1,1,0,32'h400,0, 0,0,1,0, 32'h11111111,0,32'h104, "guard_idle");
    cyc(0, 0,0,0,0, 1,0,0,32'h400,0, 0,1,1,0, 32'h11111111,0,32'h400, "guard_m1");
    idle(1, 0, 32'h44444444, "guard_m1_data");
`else
    for (int k = 16; k < 100; k++)
      cyc(0, 1,0,32'h104,0, 1,1,0,32'h400,0, 1,1,1,1, 0,32'h44444444,32'h400, "noguard_wait");
    cyc(0, 1,0,32'h104,0, 1,0,0,32'h400,0, 1,1,1,1, 0,32'h44444444,32'h400, "noguard_unlock");
    cyc(0, 1,0,32'h104,0, 0,0,0,0,0, 0,0,1,1, 0,32'h44444444,32'h104, "noguard_m0");
    idle(0, 32'h11111111, 0, "noguard_m0_data");
`endif

    // Reset the cycle after an M1 read grant: no rvalid, outputs zero, back to IDLE.
    cyc(0, 0,0,0,0, 1,1,0,32'h108,0, 0,1,1,0, 0,0,32'h108, "rst_mid_gnt");
    cyc(1, 1,0,32'h100,0, 1,1,0,32'h108,0, 0,0,0,0, 0,0,0, "rst_mid_a");
    cyc(1, 1,0,32'h100,0, 1,1,0,32'h108,0, 0,0,0,0, 0,0,0, "rst_mid_b");
    cyc(0, 1,0,32'h100,0, 0,0,0,0,0, 0,0,1,0, 0,0,32'h100, "rst_after_m0");
    idle(0, 32'hDEADBEEF, 0, "rst_after_data");

    // Drain the scoreboard with a bounded wait.
    begin
      int budget;
      budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      if (exp_q.size() > 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL drain: %0d records left, expected 0", exp_q.size());
      end
    end
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
